// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch unit.
// Walks a 5-bit program counter through a 32-entry synchronous ROM,
// resolves JMP and HALT locally and hands every other word to the decoder
// over a valid/ready handshake. All outputs come straight from registers.
module instr_fetch #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [4:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  output logic [7:0] instruction,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [4:0] pc,
  output logic       halted
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t     state_r;
  logic [4:0] pc_r;
  logic       mem_rd_r;
  logic [7:0] instruction_r;
  logic       instr_valid_r;
  logic       halted_r;

  // Next PC for sequential flow; 5-bit arithmetic wraps 31 back to 0.
  function automatic logic [4:0] pc_inc(input logic [4:0] cur);
    pc_inc = cur + 5'd1;
  endfunction

  // Fetch FSM; mem_rd/instr_valid/halted are set on the edge entering
  // REQ/ISSUE/HALTED so they are registered and aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      mem_rd_r      <= 1'b0;
      instruction_r <= 8'h00;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            state_r  <= ST_REQ;
            mem_rd_r <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            mem_rd_r <= 1'b0;
          end
        end
        ST_REQ: begin
          // ROM samples the address on this edge; data arrives in WAIT.
          state_r  <= ST_WAIT;
          mem_rd_r <= 1'b0;
        end
        ST_WAIT: begin
          case (mem_data[7:5])
            OP_HALT: begin
              // pc stays on the HALT word.
              state_r  <= ST_HALTED;
              halted_r <= 1'b1;
            end
            OP_JMP: begin
              // Jump is resolved here and never reaches the decoder.
              pc_r     <= mem_data[4:0];
              state_r  <= ST_REQ;
              mem_rd_r <= 1'b1;
            end
            default: begin
              instruction_r <= mem_data;
              instr_valid_r <= 1'b1;
              pc_r          <= pc_inc(pc_r);
              state_r       <= ST_ISSUE;
            end
          endcase
        end
        ST_ISSUE: begin
          // Hold the word until the decoder takes it; run only matters then.
          if (instr_ready) begin
            instr_valid_r <= 1'b0;
            if (run) begin
              state_r  <= ST_REQ;
              mem_rd_r <= 1'b1;
            end else begin
              state_r  <= ST_IDLE;
              mem_rd_r <= 1'b0;
            end
          end else begin
            state_r       <= ST_ISSUE;
            instr_valid_r <= 1'b1;
          end
        end
        ST_HALTED: begin
          // Sticky until reset.
          state_r  <= ST_HALTED;
          halted_r <= 1'b1;
        end
        default: begin
          state_r       <= ST_IDLE;
          mem_rd_r      <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr    = pc_r;
  assign pc          = pc_r;
  assign mem_rd      = mem_rd_r;
  assign instruction = instruction_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a per-cycle vector table for a
// RESET_PC=0 instance plus a hand-written JMP/wrap sequence on a RESET_PC=31
// instance. Each instance has its own behavioural synchronous ROM.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (RESET_PC = 0) ----------------
  logic       rst, run, instr_ready, mem_rd, instr_valid, halted;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_data, instruction;
  logic       rom_sel;
  logic [7:0] rom_a [32];
  logic [7:0] rom_b [32];

  instr_fetch #(.RESET_PC(5'd0)) u_dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .halted(halted)
  );

  // Synchronous ROM: data for the strobed address appears one cycle later.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= rom_sel ? rom_b[mem_addr] : rom_a[mem_addr];
  end

  // ---------------- instance C (RESET_PC = 31) ----------------
  logic       rst_c, run_c, rdy_c, rd_c, vld_c, hlt_c;
  logic [4:0] addr_c, pc_c;
  logic [7:0] data_c, ins_c;
  logic [7:0] rom_c [32];

  instr_fetch #(.RESET_PC(5'd31)) u_dut31 (
    .clk(clk), .rst(rst_c), .run(run_c), .mem_addr(addr_c), .mem_rd(rd_c),
    .mem_data(data_c), .instruction(ins_c), .instr_valid(vld_c),
    .instr_ready(rdy_c), .pc(pc_c), .halted(hlt_c)
  );

  // ROM for the second instance.
  always @(posedge clk) begin
    if (rd_c) data_c <= rom_c[addr_c];
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       sel;
    logic       rst;
    logic       run;
    logic       rdy;
    logic       rd;
    logic       vld;
    logic [7:0] ins;
    logic [4:0] pc;
    logic       hlt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic s, input logic r, input logic rn, input logic rd_in,
                     input logic e_rd, input logic e_v, input logic [7:0] e_i,
                     input logic [4:0] e_pc, input logic e_h);
    vec_t v;
    v.sel = s; v.rst = r; v.run = rn; v.rdy = rd_in;
    v.rd = e_rd; v.vld = e_v; v.ins = e_i; v.pc = e_pc; v.hlt = e_h;
    tv.push_back(v);
  endtask

  // Advance one edge on instance C and check its outputs 1 time unit later.
  task automatic step_c(input string nm, input logic e_rd, input logic e_v,
                        input logic [7:0] e_i, input logic [4:0] e_pc, input logic e_h);
    @(posedge clk); #1;
    chk({nm, ".rd"},  {7'd0, rd_c},  {7'd0, e_rd});
    chk({nm, ".vld"}, {7'd0, vld_c}, {7'd0, e_v});
    chk({nm, ".ins"}, ins_c, e_i);
    chk({nm, ".pc"},  {3'd0, pc_c},  {3'd0, e_pc});
    chk({nm, ".hlt"}, {7'd0, hlt_c}, {7'd0, e_h});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom_a[i] = 8'h00; rom_b[i] = 8'h00; rom_c[i] = 8'h00;
    end
    rom_a[0] = 8'h53; rom_a[1] = 8'h7F; rom_a[2] = 8'h81; rom_a[3] = 8'hE0;
    rom_b[0] = 8'hA4; rom_b[1] = 8'h12; rom_b[2] = 8'hE0;
    rom_c[31] = 8'h4A; rom_c[0] = 8'hC5; rom_c[5] = 8'h62; rom_c[6] = 8'hE0;

    rst = 1'b1; run = 1'b0; instr_ready = 1'b0; rom_sel = 1'b0;
    rst_c = 1'b1; run_c = 1'b0; rdy_c = 1'b0;

    //   sel rst run rdy | rd vld ins    pc     hlt
    // reset
    add(0, 1, 0, 0,   0, 0, 8'h00, 5'd0, 0);
    add(0, 1, 0, 0,   0, 0, 8'h00, 5'd0, 0);
    // straight line, ready held high: issues at 3-cycle spacing
    add(0, 0, 1, 1,   1, 0, 8'h00, 5'd0, 0);  // REQ
    add(0, 0, 1, 1,   0, 0, 8'h00, 5'd0, 0);  // WAIT
    add(0, 0, 1, 1,   0, 1, 8'h53, 5'd1, 0);  // ISSUE 53
    add(0, 0, 1, 1,   1, 0, 8'h53, 5'd1, 0);
    add(0, 0, 1, 1,   0, 0, 8'h53, 5'd1, 0);
    add(0, 0, 1, 1,   0, 1, 8'h7F, 5'd2, 0);  // ISSUE 7F
    add(0, 0, 1, 1,   1, 0, 8'h7F, 5'd2, 0);
    add(0, 0, 1, 1,   0, 0, 8'h7F, 5'd2, 0);
    add(0, 0, 1, 1,   0, 1, 8'h81, 5'd3, 0);  // ISSUE 81
    add(0, 0, 1, 1,   1, 0, 8'h81, 5'd3, 0);
    add(0, 0, 1, 1,   0, 0, 8'h81, 5'd3, 0);  // WAIT on HALT word
    add(0, 0, 1, 1,   0, 0, 8'h81, 5'd3, 1);  // HALTED, pc on HALT
    add(0, 0, 0, 1,   0, 0, 8'h81, 5'd3, 1);
    add(0, 0, 1, 1,   0, 0, 8'h81, 5'd3, 1);
    add(0, 0, 1, 0,   0, 0, 8'h81, 5'd3, 1);
    // reset out of HALTED, second program
    add(1, 1, 0, 0,   0, 0, 8'h00, 5'd0, 0);
    add(1, 0, 1, 0,   1, 0, 8'h00, 5'd0, 0);
    add(1, 0, 1, 0,   0, 0, 8'h00, 5'd0, 0);
    add(1, 0, 1, 0,   0, 1, 8'hA4, 5'd1, 0);  // ISSUE A4
    // backpressure for 5 cycles, run dropped during the last two
    add(1, 0, 1, 0,   0, 1, 8'hA4, 5'd1, 0);
    add(1, 0, 1, 0,   0, 1, 8'hA4, 5'd1, 0);
    add(1, 0, 1, 0,   0, 1, 8'hA4, 5'd1, 0);
    add(1, 0, 0, 0,   0, 1, 8'hA4, 5'd1, 0);
    add(1, 0, 0, 0,   0, 1, 8'hA4, 5'd1, 0);
    add(1, 0, 0, 1,   0, 0, 8'hA4, 5'd1, 0);  // handshake, run=0 -> IDLE
    add(1, 0, 0, 0,   0, 0, 8'hA4, 5'd1, 0);
    add(1, 0, 0, 1,   0, 0, 8'hA4, 5'd1, 0);
    add(1, 0, 1, 0,   1, 0, 8'hA4, 5'd1, 0);  // run back -> REQ
    add(1, 0, 1, 0,   0, 0, 8'hA4, 5'd1, 0);
    add(1, 0, 1, 0,   0, 1, 8'h12, 5'd2, 0);  // ISSUE 12
    add(1, 0, 1, 0,   0, 1, 8'h12, 5'd2, 0);
    // reset for 2 cycles mid-ISSUE drops the pending word
    add(1, 1, 1, 0,   0, 0, 8'h00, 5'd0, 0);
    add(1, 1, 1, 1,   0, 0, 8'h00, 5'd0, 0);
    add(1, 0, 0, 1,   0, 0, 8'h00, 5'd0, 0);  // IDLE, no strobe
    add(1, 0, 0, 1,   0, 0, 8'h00, 5'd0, 0);

    foreach (tv[i]) begin
      rom_sel = tv[i].sel; rst = tv[i].rst; run = tv[i].run; instr_ready = tv[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("v%0d.rd", i),  {7'd0, mem_rd},      {7'd0, tv[i].rd});
      chk($sformatf("v%0d.vld", i), {7'd0, instr_valid}, {7'd0, tv[i].vld});
      chk($sformatf("v%0d.ins", i), instruction,         tv[i].ins);
      chk($sformatf("v%0d.pc", i),  {3'd0, pc},          {3'd0, tv[i].pc});
      chk($sformatf("v%0d.addr", i), {3'd0, mem_addr},   {3'd0, tv[i].pc});
      chk($sformatf("v%0d.hlt", i), {7'd0, halted},      {7'd0, tv[i].hlt});
    end

    // JMP and wrap on the RESET_PC=31 instance.
    rst_c = 1'b1;
    step_c("c_rst", 1'b0, 1'b0, 8'h00, 5'd31, 1'b0);
    rst_c = 1'b0; run_c = 1'b1; rdy_c = 1'b1;
    step_c("c_req31",  1'b1, 1'b0, 8'h00, 5'd31, 1'b0);
    step_c("c_wait31", 1'b0, 1'b0, 8'h00, 5'd31, 1'b0);
    step_c("c_iss4a",  1'b0, 1'b1, 8'h4A, 5'd0,  1'b0);  // pc wrapped
    step_c("c_req0",   1'b1, 1'b0, 8'h4A, 5'd0,  1'b0);
    step_c("c_wait0",  1'b0, 1'b0, 8'h4A, 5'd0,  1'b0);
    step_c("c_jmp",    1'b1, 1'b0, 8'h4A, 5'd5,  1'b0);  // JMP not issued
    step_c("c_wait5",  1'b0, 1'b0, 8'h4A, 5'd5,  1'b0);
    step_c("c_iss62",  1'b0, 1'b1, 8'h62, 5'd6,  1'b0);
    step_c("c_req6",   1'b1, 1'b0, 8'h62, 5'd6,  1'b0);
    step_c("c_wait6",  1'b0, 1'b0, 8'h62, 5'd6,  1'b0);
    step_c("c_halt",   1'b0, 1'b0, 8'h62, 5'd6,  1'b1);
    run_c = 1'b0;
    step_c("c_hold",   1'b0, 1'b0, 8'h62, 5'd6,  1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Sequential instruction fetch unit that supplies 8-bit instructions to the control-unit decoder. It walks a 5-bit program counter through a 32-entry synchronous program ROM and resolves JMP and HALT locally. All other instructions go to the decoder over a valid/ready handshake. It sits between program memory and the decoder's `instruction` input.

## Interface
- `RESET_PC`, default 5'd0: program counter value after reset.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `run`  input  1  start/continue fetching; sampled in IDLE and at issue handshake.
- `mem_addr`  output  5  ROM address; always equals `pc`.
- `mem_rd`  output  1  ROM read strobe; ROM returns data exactly one cycle later.
- `mem_data`  input  8  ROM read data; valid only in the cycle after `mem_rd`.
- `instruction`  output  8  instruction to decoder: {opcode[7:5], reg[4:0]}.
- `instr_valid`  output  1  `instruction` is valid; held until accepted.
- `instr_ready`  input  1  decoder accepts; transfer when `instr_valid && instr_ready`.
- `pc`  output  5  current program counter.
- `halted`  output  1  HALT executed; sticky until `rst`.

## Operation
- Opcode field is `mem_data[7:5]`:
  - 3'b110 = JMP, target in `[4:0]`.
  - 3'b111 = HALT.
  - All other opcodes (000–101) are issued unmodified. Decoder-illegal opcodes are not filtered.
- FSM states: IDLE, REQ, WAIT, ISSUE, HALTED. Reset state is IDLE.
- IDLE:
  - `run`=1 → REQ.
  - Otherwise stay in IDLE.
- REQ: `mem_rd`=1, `mem_addr`=`pc` → WAIT.
- WAIT: `mem_data` is decoded this cycle.
  - HALT → HALTED. `pc` is unchanged (points at the HALT word).
  - JMP → `pc` <= `mem_data[4:0]`, → REQ. Not issued.
  - Otherwise → `instruction` <= `mem_data`, `pc` <= `pc`+1 mod 32 (31 wraps to 0), → ISSUE.
- ISSUE:
  - `instr_valid`=1.
  - `instruction` is held stable until the handshake completes.
  - On handshake with `run`=1 → REQ.
  - On handshake with `run`=0 → IDLE.
  - No handshake → stay in ISSUE; `run` is ignored.
- HALTED: `halted`=1. Only `rst` leaves this state; `run` is ignored.
- `mem_rd` is asserted only in REQ. `mem_data` is ignored outside WAIT.
- A JMP to its own address loops REQ/WAIT indefinitely. This is legal and no instruction is issued.

## Timing
- Reset values, taking effect on the first rising edge with `rst`=1:
  - state = IDLE
  - `pc` = `mem_addr` = RESET_PC
  - `mem_rd` = 0
  - `instruction` = 8'h00
  - `instr_valid` = 0
  - `halted` = 0
- `rst` overrides every state, including mid-fetch. ROM data in flight is discarded, and an unaccepted instruction is dropped without a handshake.
- Latency:
  - From `run` sampled high in IDLE to the first `instr_valid`: 3 cycles (IDLE→REQ→WAIT→ISSUE).
  - Each JMP in the path adds 2 cycles.
- Throughput: one instruction per 3 cycles when `instr_ready` is held high and `run`=1.
- `instr_valid` is registered. It rises on the edge entering ISSUE and falls on the edge after the handshake.
- `pc` updates at the end of WAIT, so during ISSUE it already addresses the next word.
- `halted` rises on the edge leaving WAIT with HALT and stays high.

## Test plan
- Reset: assert `rst` for 2 cycles mid-ISSUE (RESET_PC=0) → next cycle `pc`=0, `instr_valid`=0, `mem_rd`=0, `halted`=0, state IDLE.
- Straight-line, `instr_ready` held high: ROM[0..2]=8'h53, 8'h7F, 8'h81, `run`=1 → instructions 53, 7F, 81 issued 3 cycles apart; first `instr_valid` 3 cycles after `run` is sampled; `pc` sequence 1, 2, 3.
- Backpressure: `instr_ready`=0 for 5 cycles while 8'hA4 is pending → `instr_valid` and `instruction`=A4 held stable; no `mem_rd` pulses; a single transfer when `instr_ready` rises.
- JMP and wrap: ROM[31]=8'h4A, ROM[0]=8'hC5 (JMP 5), ROM[5]=8'h62, RESET_PC=31 → issue 4A; `pc` wraps to 0; JMP is not issued; next issued is 62 with `pc`=6 during ISSUE.
- HALT: ROM[3]=8'hE0 after three normal words → three issues, then `halted`=1, `pc`=3; no further `mem_rd`; `run` toggling has no effect until `rst`.
- Run drop: deassert `run` during ISSUE while `instr_ready`=0, then raise `instr_ready` → handshake completes, FSM goes to IDLE; no further `mem_rd` until `run` returns.
